// File: rtl/power_pkg.sv
// Shared definitions for the power command path: command layout, FR codes,
// sequencer states and the internal idle-timeout command.
package power_pkg;

  localparam logic [1:0] SET_FR0 = 2'b00;
  localparam logic [1:0] SET_FR1 = 2'b01;
  localparam logic [1:0] SET_FR2 = 2'b10;
  localparam logic [1:0] SET_FR3 = 2'b11;

  localparam logic OPC_LEVEL = 1'b0;
  localparam logic OPC_MODE  = 1'b1;

  localparam int CMD_W       = 4;
  localparam int CMD_OPC_BIT = 3;
  localparam int CMD_PAY_MSB = 2;
  localparam int CMD_PAY_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    HALT   = 2'd3
  } pcs_state_t;

  // Domain 1 dropped to the low-frequency clock.
  localparam logic [2:0] IDLE_LEVEL_CMD = {1'b1, SET_FR2};

  // A mode command with payload[0]=1 is a warmboot request; nothing follows it.
  function automatic logic is_warmboot(input logic [CMD_W-1:0] cmd);
    return (cmd[CMD_OPC_BIT] == OPC_MODE) && cmd[CMD_PAY_LSB];
  endfunction

endpackage

// File: rtl/pcs_cmd_fifo.sv
// Synchronous command FIFO for power_cmd_sequencer; power-of-two depth,
// pointers wrap naturally, occupancy counter drives full/empty.
module pcs_cmd_fifo #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic                              pop,
  input  logic [DATA_W-1:0]                 wdata,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/power_cmd_sequencer.sv
// Command front-end for power_manager: buffers host commands, issues one
// flag pulse per command with a settle gap, halts after a warmboot request.
// Optional idle timeout enabled by defining PCS_IDLE_TIMEOUT_EN.
module power_cmd_sequencer
  import power_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int IDLE_CYCLES   = 1000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [3:0]                        cmd_data,
  input  logic                              activity,
  output logic                              change_level_flag,
  output logic [2:0]                        change_level,
  output logic                              change_power_mode_flag,
  output logic                              change_power_mode,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  pcs_state_t        state;
  logic [SCW-1:0]    settle_cnt;
  logic [CMD_W-1:0]  cur_cmd;
  logic [CMD_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              idle_fire;

  assign cmd_ready = !fifo_full && (state != HALT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  pcs_cmd_fifo #(
    .DATA_W    (CMD_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(cmd_data),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

`ifdef PCS_IDLE_TIMEOUT_EN
  localparam int ITW = $clog2(IDLE_CYCLES+1);

  logic [ITW-1:0] idle_cnt;
  logic           idle_armed;

  // One-shot: expiry either fires (empty FIFO, IDLE) or is dropped when host
  // commands are pending; only activity or an accept re-arms it.
  always_ff @(posedge clk) begin
    if (reset || activity || push) begin
      idle_cnt   <= ITW'(IDLE_CYCLES);
      idle_armed <= 1'b1;
    end else begin
      if (idle_cnt != '0) idle_cnt <= idle_cnt - 1'b1;
      if (idle_armed && (idle_cnt == '0) && (!fifo_empty || idle_fire))
        idle_armed <= 1'b0;
    end
  end

  assign idle_fire = idle_armed && (idle_cnt == '0) && (state == IDLE) && fifo_empty;
`else
  logic unused_activity;
  assign unused_activity = activity;
  assign idle_fire       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      settle_cnt             <= '0;
      change_level_flag      <= 1'b0;
      change_level           <= '0;
      change_power_mode_flag <= 1'b0;
      change_power_mode      <= 1'b0;
    end else begin
      change_level_flag      <= 1'b0;
      change_level           <= '0;
      change_power_mode_flag <= 1'b0;
      change_power_mode      <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_cmd <= fifo_head;
            state   <= ISSUE;
          end else if (idle_fire) begin
            cur_cmd <= {OPC_LEVEL, IDLE_LEVEL_CMD};
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (cur_cmd[CMD_OPC_BIT] == OPC_MODE) begin
            change_power_mode_flag <= 1'b1;
            change_power_mode      <= cur_cmd[CMD_PAY_LSB];
          end else begin
            change_level_flag <= 1'b1;
            change_level      <= cur_cmd[CMD_PAY_MSB:CMD_PAY_LSB];
          end
          settle_cnt <= SCW'(SETTLE_CYCLES-1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= is_warmboot(cur_cmd) ? HALT : IDLE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_cmd_sequencer.sv
// Self-checking bench for power_cmd_sequencer: timeline reference model,
// table-driven single-command vectors, hand sequences and random traffic.
module tb_power_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int SC     = 16;
  localparam int IDLE_N = 100;
  localparam int CW     = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd_data = '0;
  logic          activity = 1'b0;
  logic          cmd_ready;
  logic          change_level_flag;
  logic [2:0]    change_level;
  logic          change_power_mode_flag;
  logic          change_power_mode;
  logic          busy;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  power_cmd_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .SETTLE_CYCLES(SC),
    .IDLE_CYCLES  (IDLE_N)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_data              (cmd_data),
    .activity              (activity),
    .change_level_flag     (change_level_flag),
    .change_level          (change_level),
    .change_power_mode_flag(change_power_mode_flag),
    .change_power_mode     (change_power_mode),
    .busy                  (busy),
    .fifo_count            (fifo_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 1'b1;
  bit seen_full_stall = 1'b0;

  // Reference timeline: each accepted command pulses at
  // max(accept+2, previous pulse + SC + 2), unless a warmboot came before it.
  logic [3:0] m_cmd[$];
  int         m_pulse[$];
  int         last_pulse = -1000;
  int         halt_at = -1;

  int         log_cyc[$];
  bit         log_mode[$];
  logic [2:0] log_val[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    foreach (m_cmd[i]) if (!(m_pulse[i] >= 0 && m_pulse[i] - 1 <= cyc)) n++;
    return n;
  endfunction

  function automatic bit m_halted();
    return (halt_at >= 0) && (cyc >= halt_at);
  endfunction

  function automatic bit m_ready();
    return (m_count() < DEPTH) && !m_halted();
  endfunction

  function automatic bit m_busy();
    bit b = (m_count() > 0) || m_halted();
    foreach (m_pulse[i])
      if (m_pulse[i] >= 0 && cyc >= m_pulse[i] - 1 && cyc <= m_pulse[i] + SC - 1) b = 1'b1;
    return b;
  endfunction

  task automatic model_push(input logic [3:0] d);
    int p;
    if (halt_at >= 0) p = -1;
    else begin
      p = (cyc + 2 > last_pulse + SC + 2) ? cyc + 2 : last_pulse + SC + 2;
      last_pulse = p;
      if (d[3] && d[0]) halt_at = p + SC;
    end
    m_cmd.push_back(d);
    m_pulse.push_back(p);
  endtask

  task automatic observe();
    logic       e_lf, e_mf, e_mv;
    logic [2:0] e_lv;
    if (change_level_flag) begin
      log_cyc.push_back(cyc); log_mode.push_back(1'b0); log_val.push_back(change_level);
    end
    if (change_power_mode_flag) begin
      log_cyc.push_back(cyc); log_mode.push_back(1'b1); log_val.push_back({2'b00, change_power_mode});
    end
    if (fifo_count == CW'(DEPTH) && !cmd_ready) seen_full_stall = 1'b1;
    if (model_on) begin
      e_lf = 1'b0; e_lv = '0; e_mf = 1'b0; e_mv = 1'b0;
      foreach (m_pulse[i]) if (m_pulse[i] == cyc) begin
        if (m_cmd[i][3]) begin e_mf = 1'b1; e_mv = m_cmd[i][0]; end
        else begin e_lf = 1'b1; e_lv = m_cmd[i][2:0]; end
      end
      chk("level_flag", change_level_flag, e_lf);
      chk("level", change_level, e_lv);
      chk("mode_flag", change_power_mode_flag, e_mf);
      chk("mode", change_power_mode, e_mv);
      chk("ready", cmd_ready, m_ready());
      chk("busy", busy, m_busy());
      chk("count", fifo_count, m_count());
    end
  endtask

  task automatic tick(input logic v, input logic [3:0] d, output bit acc);
    observe();
    cmd_valid = v;
    cmd_data  = d;
    acc = v && m_ready();
    @(posedge clk);
    cyc++;
    if (acc) model_push(d);
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    bit a;
    repeat (n) tick(1'b0, 4'h0, a);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; activity = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    m_cmd.delete(); m_pulse.delete(); last_pulse = -1000; halt_at = -1;
    log_cyc.delete(); log_mode.delete(); log_val.delete();
    seen_full_stall = 1'b0;
    cyc = 0;
  endtask

  typedef struct {
    logic [3:0] cmd;
    logic       lf;
    logic [2:0] lv;
    logic       mf;
    logic       mv;
    logic       halt;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] fill_cmds[6];

  initial begin
    bit a;
    int k;

    vecs[0] = '{4'b0101, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'b0000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'b0111, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'b1000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b1110, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'b1001, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{4'b1111, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1};
    fill_cmds = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0111};

    @(negedge clk);
`ifdef PCS_IDLE_TIMEOUT_EN
    model_on = 1'b0;
    do_reset();
    idle_ticks(300);
    chk("idle_pulses", log_cyc.size(), 1);
    if (log_cyc.size() > 0) begin
      chk("idle_cyc", log_cyc[0], 102);
      chk("idle_kind", log_mode[0], 1'b0);
      chk("idle_val", log_val[0], 3'b110);
    end
    do_reset();
    idle_ticks(49);
    activity = 1'b1;
    tick(1'b0, 4'h0, a);
    activity = 1'b0;
    idle_ticks(250);
    chk("act_pulses", log_cyc.size(), 1);
    if (log_cyc.size() > 0) chk("act_cyc", log_cyc[0], 152);
`else
    // Quiet after reset.
    do_reset();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_count", fifo_count, 0);
    idle_ticks(20);
    chk("quiet_busy", busy, 1'b0);
    chk("quiet_pulses", log_cyc.size(), 0);

    // Single-command vectors.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      tick(1'b1, vecs[i].cmd, a);
      idle_ticks(2);
      chk("vec_lf", change_level_flag, vecs[i].lf);
      chk("vec_lv", change_level, vecs[i].lv);
      chk("vec_mf", change_power_mode_flag, vecs[i].mf);
      chk("vec_mv", change_power_mode, vecs[i].mv);
      idle_ticks(SC + 1);
      chk("vec_ready", cmd_ready, !vecs[i].halt);
      chk("vec_busy", busy, vecs[i].halt);
    end

    // Accept at edge 10.
    do_reset();
    idle_ticks(9);
    tick(1'b1, 4'b0101, a);
    idle_ticks(2);
    chk("e12_flag", change_level_flag, 1'b1);
    chk("e12_level", change_level, 3'b101);
    idle_ticks(1);
    chk("e13_flag", change_level_flag, 1'b0);
    idle_ticks(SC + 1);
    chk("e30_busy", busy, 1'b0);

    // Hold valid with six level commands through a full FIFO.
    do_reset();
    k = 0;
    for (int t = 0; t < 80 && k < 6; t++) begin
      tick(1'b1, fill_cmds[k], a);
      if (a) k++;
    end
    cmd_valid = 1'b0;
    for (int t = 0; t < 200 && log_cyc.size() < 6; t++) idle_ticks(1);
    chk("fill_accepted", k, 6);
    chk("fill_stall", seen_full_stall, 1'b1);
    chk("fill_pulses", log_cyc.size(), 6);
    for (int i = 0; i < 6 && i < log_cyc.size(); i++) begin
      chk("fill_order", log_val[i], fill_cmds[i][2:0]);
      if (i > 0) chk("fill_gap", log_cyc[i] - log_cyc[i-1], SC + 2);
    end

    // Warmboot then a level command: halts, level never issued.
    do_reset();
    tick(1'b1, 4'b1001, a);
    tick(1'b1, 4'b0110, a);
    idle_ticks(60);
    chk("halt_pulses", log_cyc.size(), 1);
    if (log_cyc.size() > 0) begin
      chk("halt_kind", log_mode[0], 1'b1);
      chk("halt_val", log_val[0], 3'b001);
    end
    chk("halt_ready", cmd_ready, 1'b0);
    chk("halt_count", fifo_count, 1);
    do_reset();
    chk("unhalt_ready", cmd_ready, 1'b1);

    // Reset in the middle of SETTLE with commands queued.
    do_reset();
    tick(1'b1, 4'b0001, a);
    tick(1'b1, 4'b0010, a);
    tick(1'b1, 4'b0011, a);
    idle_ticks(8);
    do_reset();
    chk("midrst_count", fifo_count, 0);
    chk("midrst_flag", change_level_flag, 1'b0);
    idle_ticks(100);
    chk("midrst_pulses", log_cyc.size(), 0);

    // Random traffic against the reference timeline.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int t = 0; t < 300; t++) begin
        logic       v;
        logic [3:0] d;
        v = ($urandom_range(0, 2) == 0);
        d = 4'($urandom);
        if (d[3] && $urandom_range(0, 9) != 0) d[0] = 1'b0;
        activity = 1'($urandom);
        tick(v, d, a);
      end
    end
    activity = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/power_cmd_sequencer.md
Name: power_cmd_sequencer

Overview:
- Upstream command front-end for power_manager. Accepts power commands from the host-side bus logic over a valid/ready handshake and buffers them in a small FIFO.
- Drives power_manager's single-cycle change_level_flag/change_level and change_power_mode_flag/change_power_mode inputs.
- Enforces a minimum settle gap between successive commands so domain clock switches complete before the next one.
- Halts permanently after issuing a reconfiguration (warmboot) request.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries, power of two, ≥2.
- SETTLE_CYCLES, 16: clk cycles of dead time after each issued pulse, ≥1.
- IDLE_CYCLES, 1000000: inactivity timeout in clk cycles. Used only with PCS_IDLE_TIMEOUT_EN.

Ports:
- clk  in  1  master clock, same clock as power_manager.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept; equals !full && state!=HALT.
- cmd_data  in  4  [3]=opcode (0 level, 1 mode); [2:0]=payload.
- activity  in  1  host activity strobe; re-arms the idle timer.
- change_level_flag  out  1  one-cycle pulse to power_manager.
- change_level  out  3  [2]=domain, [1:0]=FR code; valid while flag high, else 0.
- change_power_mode_flag  out  1  one-cycle pulse.
- change_power_mode  out  1  valid while flag high, else 0.
- busy  out  1  high in ISSUE/SETTLE/HALT, or when the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset: the interface is as decided, reset reset, synchronous, active-high; clock clk.
  - All outputs 0 except cmd_ready=1.
  - FIFO flushed, state IDLE, settle counter 0, idle timer reloaded.
  - Reset in any state, including mid-SETTLE or HALT, aborts immediately. No pulse is emitted in the cycle after reset.
- Accept: push occurs on the edge where cmd_valid && cmd_ready. Data with cmd_valid low is ignored.
- FIFO:
  - Simultaneous push and pop leaves the count unchanged.
  - Push is impossible when full because ready is low.
  - Pop occurs only in IDLE.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: if the FIFO is non-empty, pop the head, latch it, and go to ISSUE.
  - ISSUE (1 cycle): registered outputs drive exactly one flag high with the latched payload. Then go to SETTLE with counter=SETTLE_CYCLES-1.
  - SETTLE: decrement the counter each cycle. At 0, go to IDLE if the last command was not mode=1, otherwise go to HALT.
  - HALT: cmd_ready=0. No further pulses are emitted. The FIFO contents are retained but never issued. Exit only via reset.
- Latency: a command accepted at edge N with the FIFO empty and state IDLE gives a flag high during the cycle after edge N+2.
- Back-to-back pulse spacing is exactly SETTLE_CYCLES+2 cycles.
- Mode command with payload[0]=0: change_power_mode=0 pulse (restore defaults). payload[2:1] is ignored.
- The two flags are never high together. Flags are never high outside ISSUE.

Optional Feature:
- Macro PCS_IDLE_TIMEOUT_EN.
- With the macro defined:
  - A counter reloads to IDLE_CYCLES on reset, on activity, and on any accept. It decrements otherwise.
  - On reaching 0 with state IDLE and the FIFO empty, an internal command level 3'b110 is issued via ISSUE/SETTLE (domain 1 to SET_FR2 low-frequency clock).
  - Fires once; re-arms only on activity or accept.
  - If the FIFO is non-empty at expiry, host commands have priority and the timeout is dropped.
  - Disabled in HALT.
- Without the macro: the timer is absent and the activity input is ignored (port kept).

Decomposition:
- Shared package power_pkg:
  - FR codes SET_FR0..SET_FR3 (2'b00..2'b11).
  - OPC_LEVEL=0 and OPC_MODE=1.
  - cmd_data bit positions.
  - State enum IDLE/ISSUE/SETTLE/HALT.
  - IDLE_LEVEL_CMD=3'b110.
- One sub-module, pcs_cmd_fifo: synchronous FIFO, width 4, depth FIFO_DEPTH, with push/pop/full/empty/count.

Test Plan:
- Reset released: cmd_ready=1, all flags 0, change_level=0, fifo_count=0, busy=0 for 20 cycles with no stimulus (macro off).
- Accept 4'b0101 at edge 10: change_level_flag=1 and change_level=3'b101 in the cycle after edge 12 only; busy=0 again after SETTLE_CYCLES+2 further cycles.
- cmd_valid held with 6 level commands, FIFO_DEPTH=4, SETTLE_CYCLES=16: cmd_ready drops when fifo_count=4. The 6 pulses appear in order, spaced exactly 18 cycles, with no command lost or duplicated.
- Accept 4'b1001 followed by 4'b0110: one change_power_mode_flag pulse with change_power_mode=1. Then HALT: cmd_ready=0 permanently and no level pulse. After reset, cmd_ready=1.
- Three commands queued, reset asserted mid-SETTLE: fifo_count=0 the cycle after reset, and no pulse for 100 cycles afterwards.
- PCS_IDLE_TIMEOUT_EN, IDLE_CYCLES=100, no activity: a single pulse with change_level=3'b110 in the cycle after edge 102 following reset release, and no second pulse. An activity strobe at cycle 50 delays the pulse by 50 cycles.
